// File: rtl/uart_arb_pkg.sv
// Shared constants and types for the uart_tx arbiter.
// Holds FSM state encoding, requester count and requester index constants.
package uart_arb_pkg;

   localparam int unsigned NUM_REQ = 2;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned REQ_CPU = 0;
   localparam int unsigned REQ_DBG = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

endpackage

// File: rtl/uart_arb_pick.sv
// Combinational round-robin picker for the uart_tx arbiter.
// Ports:
//   valid     in  per-requester byte valid
//   rr_ptr    in  preferred requester when both are valid and unlocked
//   locked    in  a message is in progress; only the owner is a candidate
//   owner     in  index of the locked owner
//   sel       out selected requester index
//   sel_valid out sel refers to a requester with a valid byte
module uart_arb_pick
   import uart_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] valid,
   input  logic               rr_ptr,
   input  logic               locked,
   input  logic               owner,
   output logic               sel,
   output logic               sel_valid
);

   // A locked owner blocks the other requester even while its own valid is low.
   always_comb begin
      sel       = 1'b0;
      sel_valid = 1'b0;
      if (locked) begin
         sel       = owner;
         sel_valid = valid[owner];
      end else if (&valid) begin
         sel       = rr_ptr;
         sel_valid = 1'b1;
      end else if (valid[REQ_DBG]) begin
         sel       = 1'b1;
         sel_valid = 1'b1;
      end else if (valid[REQ_CPU]) begin
         sel       = 1'b0;
         sel_valid = 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer between the CPU-side device (req 0) and the
// debug port (req 1). Round-robin with message locking: an owner keeps the
// transmitter until it sends a byte flagged last. Sequences start/busy.
// Optional lock timeout is built when UART_ARB_TIMEOUT_EN is defined.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_last    per-requester byte valid and end-of-message flag
//   req_data0/req_data1   requester bytes
//   req_ready             one-cycle accept pulse per requester
//   tx_start/tx_data      to uart_tx TxD_start/TxD_data
//   tx_busy               from uart_tx TxD_busy
//   grant/locked          current owner (one-hot) and message-in-progress
//   sent_count            bytes handed to uart_tx, wraps
//   timeout               pulse when a stale lock is dropped
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   parameter int unsigned CNT_W          = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [DATA_W-1:0]  req_data0,
   input  logic [DATA_W-1:0]  req_data1,
   input  logic [NUM_REQ-1:0] req_last,
   output logic [NUM_REQ-1:0] req_ready,
   output logic               tx_start,
   output logic [DATA_W-1:0]  tx_data,
   input  logic               tx_busy,
   output logic [NUM_REQ-1:0] grant,
   output logic               locked,
   output logic [CNT_W-1:0]   sent_count,
   output logic               timeout
);

   state_e               state_q, state_d;
   logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
   logic                 tx_start_q, tx_start_d;
   logic [DATA_W-1:0]    tx_data_q, tx_data_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic                 locked_q, locked_d;
   logic                 rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]     sent_count_q, sent_count_d;

   logic owner;
   logic sel;
   logic sel_valid;

   // While locked, grant holds the owner's one-hot.
   assign owner = grant_q[REQ_DBG];

   uart_arb_pick u_pick (
      .valid     (req_valid),
      .rr_ptr    (rr_ptr_q),
      .locked    (locked_q),
      .owner     (owner),
      .sel       (sel),
      .sel_valid (sel_valid)
   );

`ifdef UART_ARB_TIMEOUT_EN
   localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
   logic            timeout_q, timeout_d;

   // Idle-owner counter and timeout pulse register.
   always_ff @(posedge clk) begin
      if (reset) begin
         idle_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout = 1'b0;
`endif

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         req_ready_q  <= '0;
         tx_start_q   <= 1'b0;
         tx_data_q    <= '0;
         grant_q      <= '0;
         locked_q     <= 1'b0;
         rr_ptr_q     <= 1'b0;
         sent_count_q <= '0;
      end else begin
         state_q      <= state_d;
         req_ready_q  <= req_ready_d;
         tx_start_q   <= tx_start_d;
         tx_data_q    <= tx_data_d;
         grant_q      <= grant_d;
         locked_q     <= locked_d;
         rr_ptr_q     <= rr_ptr_d;
         sent_count_q <= sent_count_d;
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d      = state_q;
      req_ready_d  = '0;
      tx_start_d   = tx_start_q;
      tx_data_d    = tx_data_q;
      grant_d      = grant_q;
      locked_d     = locked_q;
      rr_ptr_d     = rr_ptr_q;
      sent_count_d = sent_count_q;
`ifdef UART_ARB_TIMEOUT_EN
      idle_cnt_d   = idle_cnt_q;
      timeout_d    = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            // Accept only once the serializer is idle.
            if (!tx_busy && sel_valid) begin
               req_ready_d[sel] = 1'b1;
               tx_data_d        = sel ? req_data1 : req_data0;
               grant_d          = '0;
               grant_d[sel]     = 1'b1;
               sent_count_d     = sent_count_q + CNT_W'(1);
               tx_start_d       = 1'b1;
               state_d          = ST_START;
               locked_d         = !req_last[sel];
               if (req_last[sel]) begin
                  rr_ptr_d = !sel;
               end
`ifdef UART_ARB_TIMEOUT_EN
               idle_cnt_d = '0;
`endif
            end
`ifdef UART_ARB_TIMEOUT_EN
            else if (locked_q && !req_valid[owner]) begin
               // Stale owner: drop the lock and hand priority to the other side.
               if (idle_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                  locked_d   = 1'b0;
                  grant_d    = '0;
                  rr_ptr_d   = !owner;
                  timeout_d  = 1'b1;
                  idle_cnt_d = '0;
               end else begin
                  idle_cnt_d = idle_cnt_q + TO_W'(1);
               end
            end
`endif
         end
         ST_START: begin
            if (tx_busy) begin
               tx_start_d = 1'b0;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!tx_busy) begin
               state_d = ST_IDLE;
               if (!locked_q) begin
                  grant_d = '0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign req_ready  = req_ready_q;
   assign tx_start   = tx_start_q;
   assign tx_data    = tx_data_q;
   assign grant      = grant_q;
   assign locked     = locked_q;
   assign sent_count = sent_count_q;

endmodule
